divider_arbiter: RTL and testbench

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

---
 rtl/divider_arbiter.sv | 159 +++++++++++++++
 tb/tb_divider_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// Round-robin front end for a pipelined divider: arbitrates requesters, issues
// operands, tracks ownership with a tag pipeline and returns tagged responses.
module divider_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int DIVIDEND_BITDEPTH = 8,
    parameter int DIVISOR_BITDEPTH  = 8,
    parameter int LATENCY           = 8
) (
    input  logic                                  i_sclk,
    input  logic                                  i_rstn,
    input  logic                                  i_enable,
    input  logic [NUM_REQ-1:0]                    i_req_valid,
    output logic [NUM_REQ-1:0]                    o_req_ready,
    input  logic [NUM_REQ*DIVIDEND_BITDEPTH-1:0]  i_req_dividend,
    input  logic [NUM_REQ*DIVISOR_BITDEPTH-1:0]   i_req_divisor,
    output logic                                  o_div_valid,
    output logic [DIVIDEND_BITDEPTH-1:0]          o_div_dividend,
    output logic [DIVISOR_BITDEPTH-1:0]           o_div_divisor,
    input  logic                                  i_div_valid,
    input  logic [DIVIDEND_BITDEPTH-1:0]          i_div_quotient,
    input  logic [DIVIDEND_BITDEPTH-1:0]          i_div_remainder,
    output logic                                  o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]            o_rsp_id,
    output logic [DIVIDEND_BITDEPTH-1:0]          o_rsp_quotient,
    output logic [DIVIDEND_BITDEPTH-1:0]          o_rsp_remainder,
    output logic                                  o_rsp_dbz,
    output logic                                  o_err
);

    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam int              DW      = DIVIDEND_BITDEPTH;
    localparam int              SW      = DIVISOR_BITDEPTH;
    localparam logic [ID_W:0]   NREQ_W  = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    ptr_nxt_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    win_id_s;
    logic               found_s;
    logic               hit_s;
    logic [ID_W:0]      sum_s;
    logic [ID_W-1:0]    idx_s;
    logic               accept_s;
    logic [DW-1:0]      sel_dividend_s;
    logic [SW-1:0]      sel_divisor_s;
    logic               dbz_s;

    logic [ID_W-1:0]    issue_id_r;
    logic               issue_dbz_r;
    logic               cap_valid_r;
    logic [ID_W-1:0]    cap_id_r;
    logic               cap_dbz_r;
    logic [LATENCY-1:0]           tag_valid_r;
    logic [LATENCY-1:0][ID_W-1:0] tag_id_r;
    logic [LATENCY-1:0]           tag_dbz_r;
    logic               tag_out_valid_s;
    logic               rsp_fire_s;
    logic               mismatch_s;

    // Round-robin search from ptr_r upward with wrap; first valid requester wins.
    always_comb begin
        win_id_s = '0;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s    = {1'b0, ptr_r} + (ID_W + 1)'(i);
            sum_s    = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
            idx_s    = sum_s[ID_W-1:0];
            hit_s    = i_req_valid[idx_s] & ~found_s;
            win_id_s = hit_s ? idx_s : win_id_s;
            found_s  = found_s | hit_s;
        end
        grant_s   = (i_enable && found_s) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_s) : '0;
        ptr_nxt_s = (win_id_s == LAST_ID) ? '0 : (win_id_s + 1'b1);
    end

    assign o_req_ready     = grant_s;
    assign accept_s        = |grant_s;
    assign sel_dividend_s  = i_req_dividend[int'(win_id_s)*DW +: DW];
    assign sel_divisor_s   = i_req_divisor[int'(win_id_s)*SW +: SW];
    assign dbz_s           = (sel_divisor_s == '0);

    // Issue stage: registered operands and owner tag of the accepted request.
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_r          <= '0;
            o_div_valid    <= 1'b0;
            o_div_dividend <= '0;
            o_div_divisor  <= '0;
            issue_id_r     <= '0;
            issue_dbz_r    <= 1'b0;
        end else begin
            o_div_valid <= accept_s;
            if (accept_s) begin
                ptr_r          <= ptr_nxt_s;
                o_div_dividend <= sel_dividend_s;
                o_div_divisor  <= sel_divisor_s;
                issue_id_r     <= win_id_s;
                issue_dbz_r    <= dbz_s;
            end
        end
    end

    // Tag pipeline: the cap stage mirrors the divider's input capture, then
    // LATENCY stages track its internal pipeline so the tag exits with the result.
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            cap_valid_r <= 1'b0;
            cap_id_r    <= '0;
            cap_dbz_r   <= 1'b0;
            tag_valid_r <= '0;
            tag_id_r    <= '0;
            tag_dbz_r   <= '0;
        end else begin
            cap_valid_r    <= o_div_valid;
            cap_id_r       <= issue_id_r;
            cap_dbz_r      <= issue_dbz_r;
            tag_valid_r[0] <= cap_valid_r;
            tag_id_r[0]    <= cap_id_r;
            tag_dbz_r[0]   <= cap_dbz_r;
            for (int k = 1; k < LATENCY; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_id_r[k]    <= tag_id_r[k-1];
                tag_dbz_r[k]   <= tag_dbz_r[k-1];
            end
        end
    end

    assign tag_out_valid_s = tag_valid_r[LATENCY-1];
    assign rsp_fire_s      = i_div_valid & tag_out_valid_s;
    assign mismatch_s      = i_div_valid ^ tag_out_valid_s;

    // Response register; a result without a tag (or vice versa) is dropped and flagged.
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rsp_valid     <= 1'b0;
            o_rsp_id        <= '0;
            o_rsp_quotient  <= '0;
            o_rsp_remainder <= '0;
            o_rsp_dbz       <= 1'b0;
            o_err           <= 1'b0;
        end else begin
            o_rsp_valid <= rsp_fire_s;
            if (rsp_fire_s) begin
                o_rsp_id        <= tag_id_r[LATENCY-1];
                o_rsp_dbz       <= tag_dbz_r[LATENCY-1];
                o_rsp_quotient  <= i_div_quotient;
                o_rsp_remainder <= i_div_remainder;
            end
            if (mismatch_s) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter with a reference pipelined divider
// (input capture plus LATENCY stages) attached to the divider port.
module tb_divider_arbiter;

    localparam int L = 8;

    logic        i_sclk;
    logic        i_rstn;
    logic        i_enable;
    logic [3:0]  i_req_valid;
    logic [3:0]  o_req_ready;
    logic [31:0] i_req_dividend;
    logic [31:0] i_req_divisor;
    logic        o_div_valid;
    logic [7:0]  o_div_dividend;
    logic [7:0]  o_div_divisor;
    logic        i_div_valid;
    logic [7:0]  i_div_quotient;
    logic [7:0]  i_div_remainder;
    logic        o_rsp_valid;
    logic [1:0]  o_rsp_id;
    logic [7:0]  o_rsp_quotient;
    logic [7:0]  o_rsp_remainder;
    logic        o_rsp_dbz;
    logic        o_err;

    divider_arbiter #(
        .NUM_REQ(4), .DIVIDEND_BITDEPTH(8), .DIVISOR_BITDEPTH(8), .LATENCY(L)
    ) dut (
        .i_sclk(i_sclk), .i_rstn(i_rstn), .i_enable(i_enable),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_dividend(i_req_dividend), .i_req_divisor(i_req_divisor),
        .o_div_valid(o_div_valid), .o_div_dividend(o_div_dividend),
        .o_div_divisor(o_div_divisor), .i_div_valid(i_div_valid),
        .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
        .o_rsp_quotient(o_rsp_quotient), .o_rsp_remainder(o_rsp_remainder),
        .o_rsp_dbz(o_rsp_dbz), .o_err(o_err)
    );

    initial i_sclk = 1'b0;
    always #5 i_sclk = ~i_sclk;

    // Reference divider: capture register plus L stages, reset with the DUT.
    logic            spur;
    logic [L:0]      pv;
    logic [L:0][7:0] pq;
    logic [L:0][7:0] pr;
    logic [7:0]      mq;
    logic [7:0]      mr;
    assign mq = (o_div_divisor == 8'd0) ? 8'hFF : (o_div_dividend / o_div_divisor);
    assign mr = (o_div_divisor == 8'd0) ? o_div_dividend : (o_div_dividend % o_div_divisor);
    always @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            pv <= '0;
            pq <= '0;
            pr <= '0;
        end else begin
            pv <= {pv[L-1:0], o_div_valid};
            pq <= {pq[L-1:0], mq};
            pr <= {pr[L-1:0], mr};
        end
    end
    assign i_div_valid     = pv[L] | spur;
    assign i_div_quotient  = pq[L];
    assign i_div_remainder = pr[L];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge i_sclk) cyc <= cyc + 1;

    typedef struct {
        logic        en;
        logic [3:0]  valid;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [3:0]  grant;
        logic [1:0]  id;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        int          gap;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         due;
    } exp_t;

    vec_t vecs[20];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [3:0] valid, input logic [31:0] dvd,
                                input logic [31:0] dvs, input logic [3:0] grant, input logic [1:0] id,
                                input logic [7:0] q, input logic [7:0] r, input logic dbz, input int gap);
        vec_t v;
        v.en = en; v.valid = valid; v.dvd = dvd; v.dvs = dvs; v.grant = grant;
        v.id = id; v.q = q; v.r = r; v.dbz = dbz; v.gap = gap;
        return v;
    endfunction

    // Drive one request cycle, check the grant, queue the expected response.
    task automatic apply(input vec_t v);
        exp_t e;
        i_enable       = v.en;
        i_req_valid    = v.valid;
        i_req_dividend = v.dvd;
        i_req_divisor  = v.dvs;
        @(negedge i_sclk);
        check("ready", {60'd0, o_req_ready}, {60'd0, v.grant});
        if (v.grant != 4'b0000) begin
            e.id = v.id; e.q = v.q; e.r = v.r; e.dbz = v.dbz; e.due = cyc + L + 3;
            sb.push_back(e);
        end
        @(posedge i_sclk); #1;
        for (int g = 0; g < v.gap; g++) begin
            i_req_valid = 4'b0000;
            i_enable    = 1'b1;
            @(negedge i_sclk);
            check("idle_ready", {60'd0, o_req_ready}, 64'd0);
            @(posedge i_sclk); #1;
        end
    endtask

    // Response monitor: every response must match the oldest expectation, on time.
    always @(negedge i_sclk) begin
        if (i_rstn && o_rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id",  {62'd0, o_rsp_id},        {62'd0, e.id});
                check("rsp_q",   {56'd0, o_rsp_quotient},  {56'd0, e.q});
                check("rsp_r",   {56'd0, o_rsp_remainder}, {56'd0, e.r});
                check("rsp_dbz", {63'd0, o_rsp_dbz},       {63'd0, e.dbz});
                check("rsp_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] D_ALL = {8'd7, 8'd99, 8'd45, 8'd200};
    localparam logic [31:0] S_ALL = {8'd3, 8'd10, 8'd4, 8'd13};
    logic [7:0] qa[4];
    logic [7:0] ra[4];
    vec_t v;

    initial begin
        qa = '{8'd15, 8'd11, 8'd9, 8'd2};
        ra = '{8'd5, 8'd1, 8'd9, 8'd1};
        for (int i = 0; i < 8; i++) begin
            vecs[i] = mk(1'b1, 4'b1111, D_ALL, S_ALL, 4'b0001 << (i % 4), 2'(i % 4),
                         qa[i % 4], ra[i % 4], 1'b0, (i == 7) ? 12 : 0);
        end
        vecs[8]  = mk(1'b1, 4'b0010, {8'd0, 8'd0, 8'd100, 8'd0}, {8'd0, 8'd0, 8'd7, 8'd0},
                      4'b0010, 2'd1, 8'd14, 8'd2, 1'b0, 12);
        vecs[9]  = mk(1'b1, 4'b0100, {8'd0, 8'h55, 8'd0, 8'd0}, 32'd0,
                      4'b0100, 2'd2, 8'hFF, 8'h55, 1'b1, 12);
        vecs[10] = mk(1'b1, 4'b0011, {8'd0, 8'd0, 8'd9, 8'd250}, {8'd0, 8'd0, 8'd200, 8'd250},
                      4'b0001, 2'd0, 8'd1, 8'd0, 1'b0, 0);
        vecs[11] = mk(1'b1, 4'b0011, {8'd0, 8'd0, 8'd9, 8'd250}, {8'd0, 8'd0, 8'd200, 8'd250},
                      4'b0010, 2'd1, 8'd0, 8'd9, 1'b0, 0);
        vecs[12] = mk(1'b1, 4'b1001, {8'd255, 8'd0, 8'd0, 8'd250}, {8'd1, 8'd0, 8'd0, 8'd250},
                      4'b1000, 2'd3, 8'd255, 8'd0, 1'b0, 12);
        vecs[13] = mk(1'b1, 4'b0010, {8'd0, 8'd0, 8'd60, 8'd0}, {8'd0, 8'd0, 8'd6, 8'd0},
                      4'b0010, 2'd1, 8'd10, 8'd0, 1'b0, 0);
        for (int i = 14; i < 19; i++) begin
            vecs[i] = mk(1'b0, 4'b1000, {8'd77, 24'd0}, {8'd5, 24'd0},
                         4'b0000, 2'd0, 8'd0, 8'd0, 1'b0, 0);
        end
        vecs[19] = mk(1'b1, 4'b1000, {8'd77, 24'd0}, {8'd5, 24'd0},
                      4'b1000, 2'd3, 8'd15, 8'd2, 1'b0, 12);

        i_rstn = 1'b0; i_enable = 1'b0; i_req_valid = 4'b0000;
        i_req_dividend = 32'd0; i_req_divisor = 32'd0; spur = 1'b0;
        repeat (3) @(posedge i_sclk);
        #1;
        check("reset_state", {26'd0, o_div_valid, o_div_dividend, o_div_divisor, o_rsp_valid,
                              o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_dbz, o_err}, 64'd0);
        i_rstn = 1'b1;

        for (int i = 0; i < 20; i++) apply(vecs[i]);
        check("err_after_table", {63'd0, o_err}, 64'd0);

        // Three operations in flight, then reset: everything clears and stays silent.
        v = mk(1'b1, 4'b0111, {8'd0, 8'd30, 8'd20, 8'd10}, {8'd0, 8'd3, 8'd2, 8'd1},
               4'b0001, 2'd0, 8'd10, 8'd0, 1'b0, 0);
        apply(v);
        v.grant = 4'b0010; v.id = 2'd1;
        apply(v);
        v.grant = 4'b0100; v.id = 2'd2;
        apply(v);
        i_req_valid = 4'b0000;
        i_rstn = 1'b0;
        sb.delete();
        #1;
        check("reset_midflight", {26'd0, o_div_valid, o_div_dividend, o_div_divisor, o_rsp_valid,
                                  o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_dbz, o_err}, 64'd0);
        repeat (2) @(posedge i_sclk);
        #1;
        i_rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_sclk);
            check("no_rsp_after_reset", {62'd0, o_rsp_valid, o_err}, 64'd0);
        end
        @(posedge i_sclk); #1;
        apply(mk(1'b1, 4'b1001, {8'd40, 8'd0, 8'd0, 8'd8}, {8'd9, 8'd0, 8'd0, 8'd3},
                 4'b0001, 2'd0, 8'd2, 8'd2, 1'b0, 12));

        // Spurious divider result with an empty pipeline.
        spur = 1'b1;
        @(posedge i_sclk); #1;
        spur = 1'b0;
        @(negedge i_sclk);
        check("err_set", {62'd0, o_err, o_rsp_valid}, 64'd2);
        repeat (5) @(negedge i_sclk);
        check("err_sticky", {62'd0, o_err, o_rsp_valid}, 64'd2);
        @(posedge i_sclk); #1;
        i_rstn = 1'b0;
        #1;
        check("err_reset", {63'd0, o_err}, 64'd0);
        @(posedge i_sclk); #1;
        i_rstn = 1'b1;
        apply(mk(1'b1, 4'b0100, {8'd0, 8'd200, 16'd0}, {8'd0, 8'd9, 16'd0},
                 4'b0100, 2'd2, 8'd22, 8'd2, 1'b0, 12));

        for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge i_sclk);
        check("drain", 64'(sb.size()), 64'd0);
        check("err_final", {63'd0, o_err}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
